tx_packet_fifo: RTL and testbench

- Store-and-forward AXI-Stream frame buffer placed directly upstream of the tx MAC.
- Accepts user frames on a slave AXIS port. Presents a frame on the master AXIS port only after the whole frame (tlast word) has been written.
- Once a frame starts on the master port, m00_axis_tvalid stays high until its tlast beat, as the MAC requires.
- Frames that overflow the buffer are dropped whole; a truncated frame is never forwarded.

---
 rtl/tx_packet_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_tx_packet_fifo.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_fifo.sv
// Store-and-forward AXI-Stream frame buffer feeding the tx MAC.
// A frame becomes visible on the master port only once its tlast beat is stored.
// Frames that do not fit are discarded whole. Once a frame starts on the master
// port, tvalid stays high through its tlast beat.
module tx_packet_fifo #(
    parameter int DEPTH = 512
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [63:0]              s00_axis_tdata,
    input  logic [7:0]               s00_axis_tkeep,
    input  logic                     s00_axis_tvalid,
    output logic                     s00_axis_tready,
    input  logic                     s00_axis_tlast,
    output logic [63:0]              m00_axis_tdata,
    output logic [7:0]               m00_axis_tkeep,
    output logic                     m00_axis_tvalid,
    input  logic                     m00_axis_tready,
    output logic                     m00_axis_tlast,
    output logic [$clog2(DEPTH):0]   o_frame_count,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 73;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

    typedef enum logic {WR_WRITE, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

    // Entry layout: {tlast, tkeep[7:0], tdata[63:0]}
    logic [EW-1:0]  mem [DEPTH];

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  wr_start;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  used;
    logic           full;

    wr_state_t      wr_state;
    wr_state_t      wr_state_nxt;
    rd_state_t      rd_state;
    rd_state_t      rd_state_nxt;

    logic           wr_beat;
    logic           wr_store;
    logic           wr_commit;
    logic           wr_rewind;
    logic           drop_nxt;

    logic [EW-1:0]  data_p0;
    logic           vld_p0;
    logic [EW-1:0]  data_p1;
    logic           vld_p1;

    logic           rd_avail;
    logic           fetch_ok;
    logic           rd_en;
    logic           move_p1;
    logic           rd_last_hs;
    logic [PW-1:0]  count_nxt;

    // Input is never back-pressured; overflow is resolved by dropping the frame.
    assign s00_axis_tready = 1'b1;
    assign wr_beat = s00_axis_tvalid && s00_axis_tready;

    // Occupancy counts everything written but not yet pulled out of the RAM.
    assign used = wr_ptr - rd_ptr;
    assign full = (used == PTR_DEPTH);

    // Write FSM: store beats while room remains, rewind to frame start on overflow.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_store     = 1'b0;
        wr_commit    = 1'b0;
        wr_rewind    = 1'b0;
        drop_nxt     = 1'b0;
        case (wr_state)
            WR_WRITE: begin
                if (wr_beat) begin
                    if (!full) begin
                        wr_store  = 1'b1;
                        wr_commit = s00_axis_tlast;
                    end else begin
                        wr_rewind = 1'b1;
                        if (s00_axis_tlast) begin
                            drop_nxt = 1'b1;
                        end else begin
                            wr_state_nxt = WR_DROP;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (wr_beat && s00_axis_tlast) begin
                    drop_nxt     = 1'b1;
                    wr_state_nxt = WR_WRITE;
                end
            end
            default: wr_state_nxt = WR_WRITE;
        endcase
    end

    // Write pointers, committed frame start, write state and drop pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            wr_start <= '0;
            wr_state <= WR_WRITE;
            o_drop   <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            o_drop   <= drop_nxt;
            if (wr_rewind) begin
                wr_ptr <= wr_start;
            end else if (wr_store) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_commit) begin
                wr_start <= wr_ptr + PTR_ONE;
            end
        end
    end

    // Frame storage; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (wr_store) begin
            mem[wr_ptr[AW-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
        end
    end

    // Only committed data (before wr_start) may be fetched, so partial frames stay hidden.
    assign rd_avail   = (rd_ptr != wr_start);
    assign fetch_ok   = (rd_state == RD_STREAM) || (o_frame_count != '0);
    assign move_p1    = vld_p0 && (!vld_p1 || m00_axis_tready);
    assign rd_en      = fetch_ok && rd_avail && (!vld_p0 || move_p1);
    assign rd_last_hs = vld_p1 && m00_axis_tready && data_p1[EW-1];

    // ---- stage p0: synchronous RAM read ----
    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            data_p0 <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Read pointer and valid flags for both pipeline stages.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (rd_en) begin
                vld_p0 <= 1'b1;
            end else if (move_p1) begin
                vld_p0 <= 1'b0;
            end
            if (move_p1) begin
                vld_p1 <= 1'b1;
            end else if (m00_axis_tready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // ---- stage p1: output register, held while the MAC stalls ----
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_p1 <= '0;
        end else if (move_p1) begin
            data_p1 <= data_p0;
        end
    end

    assign m00_axis_tvalid = vld_p1;
    assign m00_axis_tdata  = data_p1[63:0];
    assign m00_axis_tkeep  = data_p1[71:64];
    assign m00_axis_tlast  = data_p1[EW-1];

    // Frame count: commit adds one, tlast handshake removes one, both cancel.
    always_comb begin
        count_nxt = o_frame_count;
        if (wr_commit && !rd_last_hs) begin
            count_nxt = o_frame_count + PTR_ONE;
        end else if (!wr_commit && rd_last_hs) begin
            count_nxt = o_frame_count - PTR_ONE;
        end
    end

    // Read FSM: stream while complete frames remain, chaining frames without idling.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: begin
                if (o_frame_count != '0) begin
                    rd_state_nxt = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (rd_last_hs && (count_nxt == '0)) begin
                    rd_state_nxt = RD_IDLE;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Frame count and read state registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_frame_count <= '0;
            rd_state      <= RD_IDLE;
        end else begin
            o_frame_count <= count_nxt;
            rd_state      <= rd_state_nxt;
        end
    end

endmodule

// File: tb/tb_tx_packet_fifo.sv
// Bench for tx_packet_fifo: one default-depth instance (A) and one DEPTH=16
// instance (B) share clock, reset, write bus and MAC tready; sel picks the target.
module tb_tx_packet_fifo;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        sel;
    logic        m_tready;

    logic        s_tvalid_a, s_tready_a, m_tvalid_a, m_tlast_a, drop_a;
    logic [63:0] m_tdata_a;
    logic [7:0]  m_tkeep_a;
    logic [9:0]  cnt_a;

    logic        s_tvalid_b, s_tready_b, m_tvalid_b, m_tlast_b, drop_b;
    logic [63:0] m_tdata_b;
    logic [7:0]  m_tkeep_b;
    logic [4:0]  cnt_b;

    beat_t q_a[$];
    beat_t q_b[$];

    int total = 0;
    int bad = 0;
    int drop_cnt_a = 0;
    int drop_cnt_b = 0;
    int peak_b = 0;

    assign s_tvalid_a = s_tvalid && !sel;
    assign s_tvalid_b = s_tvalid && sel;

    always #5 clk = ~clk;

    tx_packet_fifo dut_a (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tkeep  (s_tkeep),
        .s00_axis_tvalid (s_tvalid_a),
        .s00_axis_tready (s_tready_a),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata_a),
        .m00_axis_tkeep  (m_tkeep_a),
        .m00_axis_tvalid (m_tvalid_a),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast_a),
        .o_frame_count   (cnt_a),
        .o_drop          (drop_a)
    );

    tx_packet_fifo #(.DEPTH(16)) dut_b (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tkeep  (s_tkeep),
        .s00_axis_tvalid (s_tvalid_b),
        .s00_axis_tready (s_tready_b),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata_b),
        .m00_axis_tkeep  (m_tkeep_b),
        .m00_axis_tvalid (m_tvalid_b),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast_b),
        .o_frame_count   (cnt_b),
        .o_drop          (drop_b)
    );

    // Scoreboard consumer: pops expected beats on each master handshake, checks
    // that stalled outputs hold and that tvalid never drops inside a frame.
    task automatic monitor();
        beat_t exp;
        beat_t held_a;
        beat_t held_b;
        bit    mid_a = 0, mid_b = 0, stall_a = 0, stall_b = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mid_a = 0; mid_b = 0; stall_a = 0; stall_b = 0;
                q_a.delete();
                q_b.delete();
            end else begin
                if (drop_a) drop_cnt_a++;
                if (drop_b) drop_cnt_b++;
                if (int'(cnt_b) > peak_b) peak_b = int'(cnt_b);
                if (mid_a) begin
                    total++;
                    if (m_tvalid_a !== 1'b1) begin
                        bad++;
                        $display("FAIL a_tvalid_gap got=%b want=1", m_tvalid_a);
                    end
                end
                if (stall_a) begin
                    total++;
                    if ({m_tdata_a, m_tkeep_a, m_tlast_a} !== held_a) begin
                        bad++;
                        $display("FAIL a_hold got=%h want=%h", {m_tdata_a, m_tkeep_a, m_tlast_a}, held_a);
                    end
                end
                if (mid_b) begin
                    total++;
                    if (m_tvalid_b !== 1'b1) begin
                        bad++;
                        $display("FAIL b_tvalid_gap got=%b want=1", m_tvalid_b);
                    end
                end
                if (stall_b) begin
                    total++;
                    if ({m_tdata_b, m_tkeep_b, m_tlast_b} !== held_b) begin
                        bad++;
                        $display("FAIL b_hold got=%h want=%h", {m_tdata_b, m_tkeep_b, m_tlast_b}, held_b);
                    end
                end
                stall_a = 0;
                stall_b = 0;
                if (m_tvalid_a === 1'b1 && m_tready) begin
                    total++;
                    if (q_a.size() == 0) begin
                        bad++;
                        $display("FAIL a_beat_unexpected got=%h want=none", m_tdata_a);
                    end else begin
                        exp = q_a.pop_front();
                        if ({m_tdata_a, m_tkeep_a, m_tlast_a} !== exp) begin
                            bad++;
                            $display("FAIL a_beat got=%h want=%h", {m_tdata_a, m_tkeep_a, m_tlast_a}, exp);
                        end
                    end
                    mid_a = !m_tlast_a;
                end else if (m_tvalid_a === 1'b1) begin
                    stall_a = 1;
                    held_a = {m_tdata_a, m_tkeep_a, m_tlast_a};
                    mid_a = 1;
                end
                if (m_tvalid_b === 1'b1 && m_tready) begin
                    total++;
                    if (q_b.size() == 0) begin
                        bad++;
                        $display("FAIL b_beat_unexpected got=%h want=none", m_tdata_b);
                    end else begin
                        exp = q_b.pop_front();
                        if ({m_tdata_b, m_tkeep_b, m_tlast_b} !== exp) begin
                            bad++;
                            $display("FAIL b_beat got=%h want=%h", {m_tdata_b, m_tkeep_b, m_tlast_b}, exp);
                        end
                    end
                    mid_b = !m_tlast_b;
                end else if (m_tvalid_b === 1'b1) begin
                    stall_b = 1;
                    held_b = {m_tdata_b, m_tkeep_b, m_tlast_b};
                    mid_b = 1;
                end
            end
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit keep_it);
        beat_t b;
        s_tdata = d;
        s_tkeep = k;
        s_tlast = l;
        s_tvalid = 1'b1;
        b = {d, k, l};
        if (keep_it) begin
            if (sel) q_b.push_back(b);
            else q_a.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input int id, input logic [7:0] lk, input bit keep_it);
        for (int i = 0; i < n; i++) begin
            send_beat({32'(id), 32'(i)}, (i == n - 1) ? lk : 8'hFF, (i == n - 1), keep_it);
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int c = 0; c < bound && (sel ? q_b.size() : q_a.size()) != 0; c++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tkeep = '0;
        sel = 0; m_tready = 0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (m_tvalid_a !== 1'b0 || m_tlast_a !== 1'b0 || drop_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b%b%b want=000", m_tvalid_a, m_tlast_a, drop_a);
        end
        total++;
        if (m_tdata_a !== 64'h0 || m_tkeep_a !== 8'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h want=0/0", m_tdata_a, m_tkeep_a);
        end
        total++;
        if (cnt_a !== 10'd0 || cnt_b !== 5'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d/%0d want=0/0", cnt_a, cnt_b);
        end
        total++;
        if (s_tready_a !== 1'b1 || s_tready_b !== 1'b1) begin
            bad++;
            $display("FAIL reset_tready got=%b%b want=11", s_tready_a, s_tready_b);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (s_tready_a !== 1'b1 || m_tvalid_a !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got=%b%b want=10", s_tready_a, m_tvalid_a);
        end
    endtask

    task automatic test_single_frame();
        sel = 0;
        m_tready = 1;
        send_frame(8, 0, 8'h0F, 1);
        total++;
        if (cnt_a !== 10'd1 || m_tvalid_a !== 1'b0) begin
            bad++;
            $display("FAIL single_commit got=cnt%0d v%b want=cnt1 v0", cnt_a, m_tvalid_a);
        end
        @(posedge clk);
        #1;
        total++;
        if (m_tvalid_a !== 1'b0) begin
            bad++;
            $display("FAIL single_lat1 got=%b want=0", m_tvalid_a);
        end
        @(posedge clk);
        #1;
        total++;
        if (m_tvalid_a !== 1'b1 || m_tdata_a !== 64'd0) begin
            bad++;
            $display("FAIL single_lat2 got=v%b d%h want=v1 d0", m_tvalid_a, m_tdata_a);
        end
        drain(100);
        total++;
        if (q_a.size() != 0 || cnt_a !== 10'd0) begin
            bad++;
            $display("FAIL single_drain got=q%0d cnt%0d want=q0 cnt0", q_a.size(), cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        m_tready = 1;
        fork
            begin
                for (int f = 1; f <= 3; f++) begin
                    for (int i = 0; i < 6; i++) begin
                        send_beat({32'(f), 32'(i)}, (i == 5) ? 8'h03 : 8'hFF, (i == 5), 1);
                    end
                end
                s_tvalid = 0;
                s_tlast = 0;
            end
            begin
                int w = 0;
                @(negedge clk);
                while (m_tvalid_a !== 1'b1 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 18; k++) begin
                    total++;
                    if (m_tvalid_a !== 1'b1 || m_tlast_a !== (k % 6 == 5)) begin
                        bad++;
                        $display("FAIL b2b_beat%0d got=v%b l%b want=v1 l%b", k, m_tvalid_a, m_tlast_a, (k % 6 == 5));
                    end
                    @(negedge clk);
                end
            end
        join
        drain(100);
        total++;
        if (q_a.size() != 0 || cnt_a !== 10'd0) begin
            bad++;
            $display("FAIL b2b_drain got=q%0d cnt%0d want=q0 cnt0", q_a.size(), cnt_a);
        end
    endtask

    task automatic test_backpressure();
        sel = 0;
        m_tready = 0;
        fork
            send_frame(20, 4, 8'h01, 1);
            begin
                for (int c = 0; c < 600 && (c < 30 || q_a.size() != 0); c++) begin
                    m_tready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_tready = 1;
        drain(50);
        total++;
        if (q_a.size() != 0 || cnt_a !== 10'd0) begin
            bad++;
            $display("FAIL bp_drain got=q%0d cnt%0d want=q0 cnt0", q_a.size(), cnt_a);
        end
    endtask

    task automatic test_drop();
        int d0;
        sel = 1;
        m_tready = 1;
        d0 = drop_cnt_b;
        send_frame(20, 5, 8'hFF, 0);
        total++;
        if (drop_b !== 1'b1) begin
            bad++;
            $display("FAIL drop_pulse got=%b want=1", drop_b);
        end
        @(posedge clk);
        #1;
        total++;
        if (drop_b !== 1'b0 || cnt_b !== 5'd0) begin
            bad++;
            $display("FAIL drop_after got=p%b cnt%0d want=p0 cnt0", drop_b, cnt_b);
        end
        send_frame(4, 6, 8'h7F, 1);
        drain(100);
        total++;
        if (q_b.size() != 0 || cnt_b !== 5'd0) begin
            bad++;
            $display("FAIL drop_drain got=q%0d cnt%0d want=q0 cnt0", q_b.size(), cnt_b);
        end
        total++;
        if (drop_cnt_b - d0 != 1 || peak_b != 1) begin
            bad++;
            $display("FAIL drop_stats got=drops%0d peak%0d want=drops1 peak1", drop_cnt_b - d0, peak_b);
        end
        sel = 0;
    endtask

    task automatic test_same_cycle();
        sel = 0;
        m_tready = 0;
        send_frame(1, 10, 8'h3C, 1);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (m_tvalid_a !== 1'b1 || m_tlast_a !== 1'b1) begin
            bad++;
            $display("FAIL same_hold got=v%b l%b want=v1 l1", m_tvalid_a, m_tlast_a);
        end
        for (int i = 0; i < 3; i++) begin
            send_beat({32'd11, 32'(i)}, 8'hFF, 1'b0, 1);
        end
        m_tready = 1;
        send_beat({32'd11, 32'd3}, 8'h0F, 1'b1, 1);
        s_tvalid = 0;
        s_tlast = 0;
        total++;
        if (cnt_a !== 10'd1) begin
            bad++;
            $display("FAIL same_count got=%0d want=1", cnt_a);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (m_tvalid_a !== 1'b1 || m_tdata_a !== {32'd11, 32'd0}) begin
            bad++;
            $display("FAIL same_next got=v%b d%h want=v1 d%h", m_tvalid_a, m_tdata_a, {32'd11, 32'd0});
        end
        drain(50);
        total++;
        if (q_a.size() != 0 || cnt_a !== 10'd0) begin
            bad++;
            $display("FAIL same_drain got=q%0d cnt%0d want=q0 cnt0", q_a.size(), cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        m_tready = 1;
        send_frame(16, 20, 8'hFF, 1);
        for (int i = 0; i < 8; i++) begin
            send_beat({32'd21, 32'(i)}, 8'hFF, 1'b0, 1);
        end
        total++;
        if (m_tvalid_a !== 1'b1) begin
            bad++;
            $display("FAIL mid_reading got=%b want=1", m_tvalid_a);
        end
        rst_n = 1'b0;
        s_tvalid = 0;
        #1;
        total++;
        if (m_tvalid_a !== 1'b0 || cnt_a !== 10'd0 || drop_a !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=v%b cnt%0d p%b want=v0 cnt0 p0", m_tvalid_a, cnt_a, drop_a);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(5, 22, 8'h07, 1);
        drain(50);
        total++;
        if (q_a.size() != 0 || cnt_a !== 10'd0) begin
            bad++;
            $display("FAIL mid_after got=q%0d cnt%0d want=q0 cnt0", q_a.size(), cnt_a);
        end
        total++;
        if (drop_cnt_a != 0) begin
            bad++;
            $display("FAIL a_drops got=%0d want=0", drop_cnt_a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
